voice_allocator: RTL
====================

Name: voice_allocator

Overview:
- Polyphonic voice scheduler: accepts note-on/note-off events from the MIDI/keyboard front end and assigns them to NUM_VOICES Voice instances.
- Drives each voice's 8-bit note number (F_in) and key_on.
- Handles same-note retrigger and oldest-voice stealing. Inserts a forced key_on low gap before reassigning a sounding voice so that voice's ADSR restarts its attack.

Parameters:
- NUM_VOICES, 4, number of Voice instances managed (2..16)
- AGE_W, 4, width of per-voice saturating age counter
- RETRIG_CYCLES, 2, cycles key_on is held low before a retriggered or stolen voice restarts (>=1)

Ports:
- Clk  input  1  system clock (same domain as Voice Clk)
- Reset  input  1  synchronous, active-high reset
- ev_valid  input  1  event present
- ev_ready  output  1  allocator can accept an event this cycle
- ev_note_on  input  1  1 = note-on, 0 = note-off
- ev_note  input  7  MIDI note number 0..127
- voice_note  output  8*NUM_VOICES  per-voice F_in; voice i at bits [8i+7:8i]; bit 7 always 0
- voice_key_on  output  NUM_VOICES  per-voice key_on
- steal_pulse  output  1  one-cycle pulse when a note-on steals a sounding voice
- ignore_pulse  output  1  one-cycle pulse when a note-off matches no sounding voice

Behaviour:
- Clock and reset: one clock, Clk. Reset is synchronous and active-high.
- Reset values: voice_note all 0, voice_key_on all 0, ages all 0, steal_pulse and ignore_pulse 0. State = IDLE.
- ev_ready = (state==IDLE) and not Reset, so it is 1 on the first cycle after Reset deasserts.
- Handshake: an event is accepted on a rising edge where ev_valid and ev_ready are both 1. ev_note_on and ev_note are captured into registers at that edge. Inputs are don't-care while ev_ready is 0.
- State machine: IDLE -> SCAN -> APPLY -> (GAP ->) IDLE.
  - IDLE: waits for an accepted event, then goes to SCAN with index 0.
  - SCAN: examines voice[idx] for exactly NUM_VOICES cycles, one per cycle.
    - Records the first voice with key_on=1 and a matching note: match.
    - Records the first voice with key_on=0: free.
    - Records the voice with the strictly greatest age: oldest; ties go to the lowest index.
  - APPLY (1 cycle) for note-on:
    - If match exists: target = match, retrigger.
    - Else if free exists: target = free; load note, set key_on=1, go to IDLE.
    - Else: target = oldest, steal; steal_pulse=1 for this cycle.
    - On retrigger or steal: clear key_on[target], go to GAP.
  - APPLY for note-off:
    - If match exists: clear key_on[match]. voice_note is unchanged, so release keeps its pitch.
    - Otherwise ignore_pulse=1 for this cycle.
    - Go to IDLE.
  - GAP: counts RETRIG_CYCLES cycles with key_on[target]=0. On its final edge, load voice_note[target]={0,ev_note} and set key_on[target]=1, then go to IDLE.
- Ages:
  - Updated only when a note-on sets key_on: age[target] becomes 0; every other voice's age increments, saturating at 2^AGE_W-1.
  - Note-off does not change any age.
- Latency, counted from the acceptance edge E0, with N = NUM_VOICES:
  - Free-voice note-on: key_on and voice_note update at edge E(N+1).
  - Note-off: key_on clears at edge E(N+1).
  - Retrigger or steal: key_on clears at E(N+1) and is set again with the new note at E(N+1+RETRIG_CYCLES).
  - ev_ready returns to 1 on the cycle after the final update.
  - Throughput: one event per N+2 cycles (N+2+RETRIG_CYCLES with a gap).
- Reset mid-operation: an in-flight event is discarded. All outputs return to reset values on that edge and the state returns to IDLE.
- Duplicate note-on for a note already sounding: always handled as a retrigger of that voice, never a second allocation.
- Unused events: note-off for a voice already in release (key_on=0) counts as no match and raises ignore_pulse.

Test Plan:
- Reset, then note-on 60 -> at E5 voice_key_on=0001 and voice_note[7:0]=60. ev_ready is 0 for E1..E5 and 1 after.
- Note-on 60, 64, 67, 72 -> key_on=1111; notes 60/64/67/72 in voices 0..3; ages 3/2/1/0.
- From the full state, note-on 76 -> steal_pulse at E5; voice 0 key_on low for 2 cycles; at E7 voice 0 = 76 with key_on=1; ages 0/3/2/1.
- Note-off 64 -> key_on[1]=0 with voice_note[1] still 64. Then note-on 79 -> assigned to voice 1 with no gap and no steal_pulse.
- Note-on 67 while 67 is sounding on voice 2 -> voice 2 gets a 2-cycle key_on low gap then high again; no other voice changes. Note-off 50 -> ignore_pulse, outputs unchanged.
- Assert Reset during the GAP of a steal -> next cycle all key_on=0, notes=0, ev_ready=1. A following note-on 48 lands on voice 0.

Source files
------------

// File: rtl/voice_allocator.sv
// Polyphonic voice allocator: assigns note-on/note-off events to NUM_VOICES
// voices, retriggering a voice already playing the note, stealing the oldest
// voice when none is free, and holding key_on low for RETRIG_CYCLES before a
// sounding voice is reassigned so its envelope restarts.
// Ports:
//   Clk, Reset          - clock, synchronous active-high reset
//   ev_valid/ev_ready   - event handshake (ev_ready is combinational)
//   ev_note_on, ev_note - event type (1 = on) and 7-bit MIDI note
//   voice_note          - per-voice note, voice i at [8i+7:8i], bit 7 = 0
//   voice_key_on        - per-voice key_on
//   steal_pulse         - one cycle when a note-on steals a sounding voice
//   ignore_pulse        - one cycle when a note-off matches no sounding voice
module voice_allocator #(
  parameter int unsigned NUM_VOICES    = 4,
  parameter int unsigned AGE_W         = 4,
  parameter int unsigned RETRIG_CYCLES = 2
) (
  input  logic                    Clk,
  input  logic                    Reset,
  input  logic                    ev_valid,
  output logic                    ev_ready,
  input  logic                    ev_note_on,
  input  logic [6:0]              ev_note,
  output logic [8*NUM_VOICES-1:0] voice_note,
  output logic [NUM_VOICES-1:0]   voice_key_on,
  output logic                    steal_pulse,
  output logic                    ignore_pulse
);

  localparam int unsigned IDX_W = (NUM_VOICES > 1) ? $clog2(NUM_VOICES) : 1;
  localparam int unsigned CNT_W = (RETRIG_CYCLES > 1) ? $clog2(RETRIG_CYCLES) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_VOICES - 1);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(RETRIG_CYCLES - 1);
  localparam logic [AGE_W-1:0] AGE_MAX  = '1;

  typedef enum logic [1:0] {IDLE, SCAN, APPLY, GAP} state_t;

  state_t state_q, state_d;

  logic [IDX_W-1:0]      idx_q;
  logic                  op_on_q;
  logic [6:0]            op_note_q;
  logic                  match_found_q, free_found_q;
  logic [IDX_W-1:0]      match_idx_q, free_idx_q, oldest_idx_q, target_q;
  logic [AGE_W-1:0]      oldest_age_q;
  logic [CNT_W-1:0]      gap_cnt_q;
  logic [6:0]            note_q [NUM_VOICES];
  logic [AGE_W-1:0]      age_q  [NUM_VOICES];
  logic [NUM_VOICES-1:0] key_on_q;

  logic                  set_c, clear_c, steal_c, ignore_c;
  logic [IDX_W-1:0]      set_idx_c, clear_idx_c, tgt_c;

  assign ev_ready     = (state_q == IDLE) && !Reset;
  assign voice_key_on = key_on_q;

  // Pack per-voice notes onto the flat output bus.
  always_comb begin
    voice_note = '0;
    for (int i = 0; i < NUM_VOICES; i++) begin
      voice_note[8*i +: 8] = {1'b0, note_q[i]};
    end
  end

  // State register.
  always_ff @(posedge Clk) begin
    if (Reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Next state and per-cycle voice update strobes.
  always_comb begin
    state_d     = state_q;
    set_c       = 1'b0;
    set_idx_c   = '0;
    clear_c     = 1'b0;
    clear_idx_c = '0;
    steal_c     = 1'b0;
    ignore_c    = 1'b0;
    // Note-on priority: retrigger matching voice, then free voice, then oldest.
    tgt_c = match_found_q ? match_idx_q : (free_found_q ? free_idx_q : oldest_idx_q);
    unique case (state_q)
      IDLE: if (ev_valid) state_d = SCAN;
      SCAN: if (idx_q == LAST_IDX) state_d = APPLY;
      APPLY: begin
        state_d = IDLE;
        if (op_on_q) begin
          if (!match_found_q && free_found_q) begin
            set_c     = 1'b1;
            set_idx_c = tgt_c;
          end else begin
            clear_c     = 1'b1;
            clear_idx_c = tgt_c;
            steal_c     = !match_found_q;
            state_d     = GAP;
          end
        end else if (match_found_q) begin
          clear_c     = 1'b1;
          clear_idx_c = match_idx_q;
        end else begin
          ignore_c = 1'b1;
        end
      end
      GAP: begin
        if (gap_cnt_q == LAST_CNT) begin
          set_c     = 1'b1;
          set_idx_c = target_q;
          state_d   = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Event capture, voice scan and voice state.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      idx_q         <= '0;
      op_on_q       <= 1'b0;
      op_note_q     <= '0;
      match_found_q <= 1'b0;
      free_found_q  <= 1'b0;
      match_idx_q   <= '0;
      free_idx_q    <= '0;
      oldest_idx_q  <= '0;
      oldest_age_q  <= '0;
      target_q      <= '0;
      gap_cnt_q     <= '0;
      key_on_q      <= '0;
      steal_pulse   <= 1'b0;
      ignore_pulse  <= 1'b0;
      for (int i = 0; i < NUM_VOICES; i++) begin
        note_q[i] <= '0;
        age_q[i]  <= '0;
      end
    end else begin
      steal_pulse  <= steal_c;
      ignore_pulse <= ignore_c;

      if (state_q == IDLE && ev_valid) begin
        op_on_q       <= ev_note_on;
        op_note_q     <= ev_note;
        idx_q         <= '0;
        match_found_q <= 1'b0;
        free_found_q  <= 1'b0;
        oldest_idx_q  <= '0;
        oldest_age_q  <= '0;
      end

      if (state_q == SCAN) begin
        idx_q <= idx_q + IDX_W'(1);
        if (!match_found_q && key_on_q[idx_q] && note_q[idx_q] == op_note_q) begin
          match_found_q <= 1'b1;
          match_idx_q   <= idx_q;
        end
        if (!free_found_q && !key_on_q[idx_q]) begin
          free_found_q <= 1'b1;
          free_idx_q   <= idx_q;
        end
        // Strict compare keeps the lowest index on ties.
        if (age_q[idx_q] > oldest_age_q) begin
          oldest_age_q <= age_q[idx_q];
          oldest_idx_q <= idx_q;
        end
      end

      if (state_q == APPLY) begin
        target_q  <= tgt_c;
        gap_cnt_q <= '0;
      end

      if (state_q == GAP) gap_cnt_q <= gap_cnt_q + CNT_W'(1);

      if (clear_c) key_on_q[clear_idx_c] <= 1'b0;

      if (set_c) begin
        note_q[set_idx_c]   <= op_note_q;
        key_on_q[set_idx_c] <= 1'b1;
        for (int i = 0; i < NUM_VOICES; i++) begin
          if (IDX_W'(i) == set_idx_c)  age_q[i] <= '0;
          else if (age_q[i] != AGE_MAX) age_q[i] <= age_q[i] + AGE_W'(1);
        end
      end
    end
  end

endmodule
